fetch_ctrl: RTL and testbench

Sequencer between the PC stage and the instruction memory port. It takes the current and next PC from the PC stage, issues one instruction fetch at a time over a valid/ready request channel, and captures the response. It presents the instruction to the decode stage with a valid/ready handshake and drives the PC stage's ready so the PC advances only when an instruction retires into decode or on a redirect. On a redirect it squashes in-flight and buffered wrong-path fetches.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_fetch_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_WIDTH = 32;
  localparam int unsigned FETCH_DATA_WIDTH = 32;
  localparam logic [31:0] FETCH_ADDR_INIT  = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Single-outstanding fetch sequencer between the PC stage and the instruction
// memory port, with a one-entry decode buffer and wrong-path squash on redirect.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] ADDR_INIT  = FETCH_ADDR_INIT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [ADDR_WIDTH-1:0] i_pc_next,
  output logic                  o_ifu_ready,
  input  logic                  i_redirect,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rsp_data,
  input  logic                  i_mem_rsp_err,
  output logic                  o_inst_valid,
  input  logic                  i_inst_ready,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic [ADDR_WIDTH-1:0] o_inst_pc,
  output logic                  o_inst_err
);

  fetch_state_t          state_q, state_d;
  logic                  kill_q, kill_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] instPc_q, instPc_d;
  logic                  instErr_q, instErr_d;
  logic                  reqValid, instValid, ifuReady;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      kill_q    <= 1'b0;
      addr_q    <= ADDR_INIT;
      inst_q    <= '0;
      instPc_q  <= '0;
      instErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      instPc_q  <= instPc_d;
      instErr_q <= instErr_d;
    end
  end

  // addr_d only moves on transitions into S_REQ, so the request stays registered and stable.
  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    instPc_d  = instPc_q;
    instErr_d = instErr_q;
    reqValid  = 1'b0;
    instValid = 1'b0;
    ifuReady  = i_redirect;

    unique case (state_q)
      S_IDLE: begin
        addr_d  = i_pc;
        state_d = S_REQ;
      end
      S_REQ: begin
        reqValid = 1'b1;
        if (i_redirect) kill_d = 1'b1;
        if (i_mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_mem_rsp_valid) begin
          if (kill_q || i_redirect) begin
            // A same-cycle redirect means the PC stage is loading i_pc_next right now.
            kill_d  = 1'b0;
            addr_d  = i_redirect ? i_pc_next : i_pc;
            state_d = S_REQ;
          end else begin
            inst_d    = i_mem_rsp_data;
            instPc_d  = addr_q;
            instErr_d = i_mem_rsp_err;
            state_d   = S_HOLD;
          end
        end else if (i_redirect) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        instValid = !i_redirect;
        ifuReady  = i_redirect | i_inst_ready;
        if (i_redirect || i_inst_ready) begin
          addr_d  = i_pc_next;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!i_rst_n) begin
      reqValid  = 1'b0;
      instValid = 1'b0;
      ifuReady  = 1'b0;
    end
  end

  assign o_mem_req_valid = reqValid;
  assign o_mem_addr      = addr_q;
  assign o_inst_valid    = instValid;
  assign o_inst          = inst_q;
  assign o_inst_pc       = instPc_q;
  assign o_inst_err      = instErr_q;
  assign o_ifu_ready     = ifuReady;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed memory/decode stimulus with a PC-stage model.
module tb_fetch_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } expInst_t;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_pc;
  logic [31:0] i_pc_next;
  logic        o_ifu_ready;
  logic        i_redirect;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [31:0] o_mem_addr;
  logic        i_mem_rsp_valid;
  logic [31:0] i_mem_rsp_data;
  logic        i_mem_rsp_err;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_inst_err;

  logic [31:0] pc;
  logic [31:0] target;
  int          testsRun;
  int          testsFailed;
  logic [31:0] expAddrQ[$];
  expInst_t    expInstQ[$];
  expInst_t    popped;

  fetch_ctrl dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_pc           (i_pc),
    .i_pc_next      (i_pc_next),
    .o_ifu_ready    (o_ifu_ready),
    .i_redirect     (i_redirect),
    .o_mem_req_valid(o_mem_req_valid),
    .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr     (o_mem_addr),
    .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_data (i_mem_rsp_data),
    .i_mem_rsp_err  (i_mem_rsp_err),
    .o_inst_valid   (o_inst_valid),
    .i_inst_ready   (i_inst_ready),
    .o_inst         (o_inst),
    .o_inst_pc      (o_inst_pc),
    .o_inst_err     (o_inst_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // PC stage model: advances to pc+4, or loads the jump target, on each ifu_ready pulse.
  assign i_pc_next = i_redirect ? target : pc + 32'd4;
  assign i_pc      = pc;

  always @(posedge i_clk) begin
    if (!i_rst_n) pc <= 32'h8000_0000;
    else if (o_ifu_ready) pc <= i_pc_next;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs just after the clock edge, then return mid-cycle for sampling.
  task automatic applyStimulus(input logic reqReady, input logic rspValid, input logic [31:0] rspData,
                               input logic rspErr, input logic instReady, input logic redirect,
                               input logic [31:0] tgt);
    @(posedge i_clk);
    #1;
    i_mem_req_ready = reqReady;
    i_mem_rsp_valid = rspValid;
    i_mem_rsp_data  = rspData;
    i_mem_rsp_err   = rspErr;
    i_inst_ready    = instReady;
    i_redirect      = redirect;
    target          = tgt;
    #2;
  endtask

  // Scoreboard: every request handshake and every instruction handshake consumes one expectation.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_mem_req_valid && i_mem_req_ready) begin
        checkOutput("reqExpected", 32'(expAddrQ.size() != 0), 1);
        if (expAddrQ.size() != 0) checkOutput("reqAddr", o_mem_addr, expAddrQ.pop_front());
      end
      if (o_inst_valid && i_inst_ready) begin
        checkOutput("instExpected", 32'(expInstQ.size() != 0), 1);
        if (expInstQ.size() != 0) begin
          popped = expInstQ.pop_front();
          checkOutput("instData", o_inst, popped.data);
          checkOutput("instPc", o_inst_pc, popped.pc);
          checkOutput("instErr", 32'(o_inst_err), 32'(popped.err));
        end
      end
    end
  end

  initial begin
    testsRun        = 0;
    testsFailed     = 0;
    i_rst_n         = 1'b0;
    i_redirect      = 1'b0;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_data  = '0;
    i_mem_rsp_err   = 1'b0;
    i_inst_ready    = 1'b0;
    target          = '0;

    repeat (3) @(posedge i_clk);
    #3;
    checkOutput("rstReqValid", 32'(o_mem_req_valid), 0);
    checkOutput("rstInstValid", 32'(o_inst_valid), 0);
    checkOutput("rstMemAddr", o_mem_addr, 32'h8000_0000);
    checkOutput("rstInst", o_inst, 0);
    checkOutput("rstInstPc", o_inst_pc, 0);
    checkOutput("rstInstErr", 32'(o_inst_err), 0);
    checkOutput("rstIfuReady", 32'(o_ifu_ready), 0);

    // c0: IDLE after release
    @(posedge i_clk);
    #1;
    i_rst_n         = 1'b1;
    i_mem_req_ready = 1'b1;
    i_inst_ready    = 1'b1;
    expAddrQ.push_back(32'h8000_0000);
    #2;
    checkOutput("idleReqValid", 32'(o_mem_req_valid), 0);

    // c1: request accepted at once
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("c1ReqValid", 32'(o_mem_req_valid), 1);
    checkOutput("c1Addr", o_mem_addr, 32'h8000_0000);

    // c2: response
    applyStimulus(1, 1, 32'h0000_0013, 0, 1, 0, 0);
    expInstQ.push_back('{32'h0000_0013, 32'h8000_0000, 1'b0});
    checkOutput("c2InstValid", 32'(o_inst_valid), 0);

    // c3: instruction to decode, PC advance pulse
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    expAddrQ.push_back(32'h8000_0004);
    checkOutput("c3InstValid", 32'(o_inst_valid), 1);
    checkOutput("c3InstPc", o_inst_pc, 32'h8000_0000);
    checkOutput("c3IfuReady", 32'(o_ifu_ready), 1);

    // c4: request 8000_0004, c5: response, decode about to stall
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 32'h0040_0093, 0, 0, 0, 0);
    expInstQ.push_back('{32'h0040_0093, 32'h8000_0004, 1'b0});

    // decode stall for 5 cycles in HOLD
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("stallValid", 32'(o_inst_valid), 1);
      checkOutput("stallInst", o_inst, 32'h0040_0093);
      checkOutput("stallInstPc", o_inst_pc, 32'h8000_0004);
      checkOutput("stallIfuReady", 32'(o_ifu_ready), 0);
      checkOutput("stallNoReq", 32'(o_mem_req_valid), 0);
      checkOutput("stallPc", pc, 32'h8000_0004);
    end

    // accept; memory then stalls the next request
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    expAddrQ.push_back(32'h8000_0008);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("bpReqValid", 32'(o_mem_req_valid), 1);
      checkOutput("bpAddr", o_mem_addr, 32'h8000_0008);
    end
    applyStimulus(1, 0, 0, 0, 1, 0, 0);

    // redirect in WAIT, response 3 cycles later must be discarded
    applyStimulus(1, 0, 0, 0, 1, 1, 32'h8000_0100);
    checkOutput("waitRedirIfuReady", 32'(o_ifu_ready), 1);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    expAddrQ.push_back(32'h8000_0100);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 32'hDEAD_BEEF, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("killNoValid", 32'(o_inst_valid), 0);
    checkOutput("killAddr", o_mem_addr, 32'h8000_0100);

    // response for 8000_0100, then redirect in HOLD with decode ready
    applyStimulus(1, 1, 32'h0000_0513, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 1, 32'h8000_0200);
    expAddrQ.push_back(32'h8000_0200);
    checkOutput("holdRedirValid", 32'(o_inst_valid), 0);
    checkOutput("holdRedirIfuReady", 32'(o_ifu_ready), 1);

    // faulting fetch passes through, stream continues at pc+4
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 32'h1234_5678, 1, 1, 0, 0);
    expInstQ.push_back('{32'h1234_5678, 32'h8000_0200, 1'b1});
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    expAddrQ.push_back(32'h8000_0204);
    checkOutput("errValid", 32'(o_inst_valid), 1);
    checkOutput("errFlag", 32'(o_inst_err), 1);
    checkOutput("errPc", o_inst_pc, 32'h8000_0200);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("errNextAddr", o_mem_addr, 32'h8000_0204);
    applyStimulus(1, 1, 32'h0000_0013, 0, 1, 0, 0);
    expInstQ.push_back('{32'h0000_0013, 32'h8000_0204, 1'b0});

    // HOLD accept with a stray response; next request stalls and is redirected before acceptance
    applyStimulus(0, 1, 32'hFFFF_FFFF, 0, 1, 0, 0);
    expAddrQ.push_back(32'h8000_0208);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h8000_0300);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    expAddrQ.push_back(32'h8000_0300);
    applyStimulus(1, 1, 32'hBAD0_BAD0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("reqKillAddr", o_mem_addr, 32'h8000_0300);
    applyStimulus(1, 1, 32'h0000_0113, 0, 1, 0, 0);
    expInstQ.push_back('{32'h0000_0113, 32'h8000_0300, 1'b0});
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 1, 0, 0);

    checkOutput("addrQueueDrained", 32'(expAddrQ.size()), 0);
    checkOutput("instQueueDrained", 32'(expInstQ.size()), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
